sram_stream_reader: RTL
=======================

# sram_stream_reader

Read-side initiator for the banked 1RW SRAM wrapper: on a start pulse it issues a burst of sequential reads (csb/web active-low, one-cycle read latency) and presents the returned words on a valid/ready output stream. A 2-entry skid FIFO absorbs the fixed SRAM latency so downstream backpressure never loses a word. It sits between the SRAM wrapper and any consumer (DMA, compute array) that drains memory as a stream.

## Interface
- DATA_WIDTH, 128, word width; equals the SRAM wrapper width
- ADDR_BITS, 9, SRAM address width
- DEPTH, 384, number of valid SRAM words; addresses wrap from DEPTH-1 to 0
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- base_addr  input  ADDR_BITS  first word address; must be < DEPTH; sampled with start
- count  input  ADDR_BITS+1  words to read; 0 legal; values > DEPTH re-read wrapped addresses
- busy  output  1  high while a burst is in progress
- done  output  1  one-cycle pulse at burst completion
- sram_csb  output  1  active-low chip select to SRAM wrapper
- sram_web  output  1  active-low write enable; constant 1
- sram_addr  output  ADDR_BITS  read address
- sram_din  output  DATA_WIDTH  constant 0
- sram_dout  input  DATA_WIDTH  read data, valid the cycle after the read edge only
- out_valid  output  1  stream word available
- out_ready  input  1  consumer accepts when valid && ready
- out_data  output  DATA_WIDTH  stream word; stable while valid && !ready

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start && count!=0 -> latch addr=base_addr, remaining=count, go RUN, busy=1. start && count==0 -> done next cycle, no SRAM access, stay IDLE, busy stays 0.
- RUN: read issued in a cycle when remaining!=0 and occ + inflight - pop < 2 (occ = FIFO entries, inflight = read issued last cycle, pop = out_valid && out_ready this cycle). Issue: sram_csb=0, sram_addr=addr; at the edge addr advances (DEPTH-1 -> 0) and remaining decrements. When the last read is issued -> DRAIN.
- sram_csb/sram_addr are combinational from registered state and out_ready; sram_csb=1 whenever no read is issued.
- Capture: cycle after an issue, sram_dout is written into the FIFO at the edge (unconditionally; space is guaranteed by the issue rule).
- FIFO: 2 entries, in-order; out_valid = occ!=0; out_data = head entry. Simultaneous push and pop allowed at any occupancy, including occ=2 with pop.
- DRAIN: wait until inflight==0 and occ==0 after the last word is popped -> IDLE, done=1 that next cycle, busy=0 same cycle as done.
- start while busy is ignored (no effect on current burst).
- Never drives a write: sram_web=1, sram_din=0 always.

## Timing
- Reset (async, immediate): state IDLE, busy=0, done=0, sram_csb=1, sram_web=1, sram_addr=0, out_valid=0, out_data=0, FIFO empty, inflight cleared; any in-flight read data is discarded.
- start sampled at edge ending cycle 0: first read in cycle 1, data on sram_dout in cycle 2, out_valid=1 in cycle 3 (start-to-first-word latency 3).
- With out_ready=1 continuously: one read per cycle, one output word per cycle; count=N burst delivers words in cycles 3..N+2, done in cycle N+3.
- With out_ready=0: at most 2 reads issued beyond the last pop; issuing stalls, no word dropped or duplicated; resumes the cycle out_ready returns high.
- done is never asserted in the same cycle as out_valid for the same burst.
- count==0: done pulses in cycle 1; sram_csb stays 1.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs at reset values before next edge; sram_csb=1.
- Burst: SRAM preloaded data[i]=i, base_addr=5, count=4, out_ready=1 -> out_data 5,6,7,8 in cycles 3..6, done in cycle 7, busy high cycles 1..6.
- Backpressure: base_addr=0, count=8, out_ready toggled random 50% -> exactly words 0..7 in order, never more than 2 reads ahead of pops, out_data stable while stalled.
- Wrap: base_addr=382, count=4 (DEPTH=384) -> sram_addr 382,383,0,1; output words 382,383,0,1.
- Zero/ignored start: count=0 -> done in cycle 1, no csb low; start pulsed during busy burst of count=6 -> exactly 6 words, one done.
- Reset mid-burst: rst_n low after 3 of 10 words delivered -> out_valid drops immediately, no further reads; new start base_addr=0 count=2 afterwards -> words 0,1 only.

Source files
------------

// File: rtl/sram_stream_reader.sv
// Burst read initiator for the banked 1RW SRAM wrapper; streams returned words
// over valid/ready through a 2-entry skid FIFO covering the one-cycle read latency.
`timescale 1ns/1ps
module sram_stream_reader #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_BITS  = 9,
  parameter int DEPTH      = 384
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [ADDR_BITS:0]    count,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_BITS-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  state_t                state_r;
  state_t                state_s;
  logic [ADDR_BITS-1:0]  addr_r;
  logic [ADDR_BITS:0]    remaining_r;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] fifo_r [2];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            occ_r;
  logic                  done_r;

  logic                  pop_s;
  logic                  issue_s;
  logic                  last_issue_s;
  logic                  drain_exit_s;
  logic                  done_s;
  logic [2:0]            level_s;
  logic [2:0]            limit_s;

  assign pop_s        = (occ_r != 2'd0) && out_ready;
  // Entries already held plus the word landing next edge must leave room for this read.
  assign level_s      = {1'b0, occ_r} + {2'b00, inflight_r};
  assign limit_s      = 3'd2 + {2'b00, pop_s};
  assign last_issue_s = issue_s && (remaining_r == (ADDR_BITS+1)'(1));
  assign drain_exit_s = !inflight_r && ((occ_r == 2'd0) || ((occ_r == 2'd1) && pop_s));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (count != '0)) state_s = ST_RUN;
        else                        state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_issue_s) state_s = ST_DRAIN;
        else              state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (drain_exit_s) state_s = ST_IDLE;
        else              state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode: read issue and done request
  always_comb begin
    issue_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        issue_s = 1'b0;
        done_s  = start && (count == '0);
      end
      ST_RUN: begin
        issue_s = (remaining_r != '0) && (level_s < limit_s);
        done_s  = 1'b0;
      end
      ST_DRAIN: begin
        issue_s = 1'b0;
        done_s  = drain_exit_s;
      end
      default: begin
        issue_s = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Done pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_s;
    end
  end

  // Burst address / remaining counter and read-in-flight flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= {ADDR_BITS{1'b0}};
      remaining_r <= {(ADDR_BITS+1){1'b0}};
      inflight_r  <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if ((state_r == ST_IDLE) && start) begin
        addr_r      <= base_addr;
        remaining_r <= count;
      end else if (issue_s) begin
        addr_r      <= (addr_r == LAST_ADDR) ? {ADDR_BITS{1'b0}} : addr_r + ADDR_BITS'(1);
        remaining_r <= remaining_r - (ADDR_BITS+1)'(1);
      end else begin
        addr_r      <= addr_r;
        remaining_r <= remaining_r;
      end
    end
  end

  // Skid FIFO: capture returning read data, pop on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_r[0] <= {DATA_WIDTH{1'b0}};
      fifo_r[1] <= {DATA_WIDTH{1'b0}};
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      occ_r     <= 2'd0;
    end else begin
      if (inflight_r) begin
        fifo_r[wr_ptr_r] <= sram_dout;
        wr_ptr_r         <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({inflight_r, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;
  assign sram_csb  = ~issue_s;
  assign sram_web  = 1'b1;
  assign sram_addr = issue_s ? addr_r : {ADDR_BITS{1'b0}};
  assign sram_din  = {DATA_WIDTH{1'b0}};
  assign out_valid = (occ_r != 2'd0);
  assign out_data  = fifo_r[rd_ptr_r];

endmodule
